level_controller: RTL and testbench
===================================

Name: level_controller

Overview:
- Sequencer for the level-coding stage of the H.264 CAVLC entropy encoder.
- Scans the 4x4 block coefficient BRAM in reverse zig-zag order and skips the trailing ones.
- For each remaining non-zero coefficient, computes level_code and tracks suffixLength.
- Drives the level_prefix and level_suffix encoder sub-blocks through start/finish handshakes, then signals completion to the top-level CAVLC controller.

Parameters:
- DATA_WIDTH, 9, width of a signed coefficient word read from BRAM.
- STATE_WIDTH, 4, width of the FSM state register.
- NZQ_WIDTH, 5, width of the TotalCoeff (non-zero count, 0..16) input.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start_levels  in  1  one-cycle start pulse; NZQ and T1s are valid in that cycle.
- NZQ  in  NZQ_WIDTH  TotalCoeff of the block.
- T1s  in  2  TrailingOnes count (0..3).
- prefix_finish  in  1  level_prefix encoder done (level-sampled).
- suffix_finish  in  1  level_suffix encoder done (level-sampled).
- mb_bram_data  in  DATA_WIDTH signed  coefficient at mb_bram_address; combinational read, valid in the same cycle.
- finish_levels  out  1  one-cycle pulse when all levels are emitted.
- output_mux  out  1  bitstream source select: 0=prefix, 1=suffix.
- prefix_start  out  1  pulse; prefix encoder computes prefix from level_code/suffix_len.
- prefix_start_out  out  1  pulse; prefix encoder shifts its bits into the stream.
- suffix_start  out  1  pulse; suffix encoder computes suffix.
- suffix_start_out  out  1  pulse; suffix encoder shifts its bits out.
- mb_bram_en  out  1  BRAM read enable, high while scanning.
- mb_bram_address  out  4  coefficient address; zig-zag index 0..15.
- suffix_len  out  3  current suffixLength (0..6).
- level_code  out  DATA_WIDTH+1 signed  levelCode of the current coefficient.

Behaviour:
- Reset (async): state=IDLE; all outputs 0; address=15; internal skip and encoded counters cleared.
- FSM states: IDLE, SCAN, CALC, PRE, PRE_W, PRE_OUT, PRE_OUT_W, SUF, SUF_W, SUF_OUT, SUF_OUT_W, UPDATE, DONE.
- IDLE, on start_levels:
  - Latch NZQ and T1s.
  - suffix_len <= (NZQ>10 && T1s<3) ? 1 : 0.
  - address <= 15; clear counters.
  - If NZQ==T1s (includes NZQ=0), go to DONE; else go to SCAN.
  - start_levels is ignored outside IDLE.
- SCAN: mb_bram_en=1; examine mb_bram_data at the current address, one address per cycle.
  - Zero: address decrements.
  - Non-zero with skip count < T1s: skip count++, address decrements.
  - Non-zero otherwise: latch the coefficient, go to CALC.
- CALC, with coefficient c:
  - level_code <= c>0 ? 2c-2 : -2c-1.
  - If this is the first encoded level and T1s<3, subtract 2 from level_code.
  - Go to PRE.
- Handshake stages, each a one-cycle start pulse followed by a wait state:
  - PRE: prefix_start=1 for one cycle. PRE_W: wait for prefix_finish=1.
  - PRE_OUT: output_mux=0, prefix_start_out=1 for one cycle. PRE_OUT_W: wait for prefix_finish=1.
  - SUF: suffix_start=1 for one cycle. SUF_W: wait for suffix_finish=1.
  - SUF_OUT: output_mux=1, suffix_start_out=1 for one cycle. SUF_OUT_W: wait for suffix_finish=1.
  - finish inputs are sampled only in wait states. A finish held high continuously advances the FSM on the first cycle of each wait state.
  - The suffix stages always run; the suffix encoder may emit zero bits.
- UPDATE, using the pre-update suffix_len:
  - If suffix_len==0, set it to 1.
  - Then, if |c| > (3 << (suffix_len-1)) and suffix_len<6, increment it.
  - Encoded count++. If T1s + encoded == NZQ, go to DONE; else decrement address and go to SCAN.
- DONE: finish_levels=1 for one cycle, then IDLE.
- level_code and suffix_len hold their values until the next CALC/UPDATE or the next start.
- If the address reaches 0 without meeting the count (inconsistent NZQ), go to DONE after address 0 is examined.
- output_mux holds its last value outside the _OUT states.
- Reset mid-operation aborts immediately to IDLE; no finish_levels is issued.

Test Plan:
- Coefficients addr0..4 = {3, -2, 1, -1, 1}, rest 0; NZQ=5, T1s=3; finish inputs held high. Required response:
  - Addresses 15..2 are scanned, 4/3/2 skipped.
  - level_code=3, suffix_len=0 during the first prefix/suffix handshake.
  - level_code=4, suffix_len=1 for the second.
  - Final suffix_len=1; a single finish_levels pulse.
- addr0..2 = {2, 1, -1}; NZQ=3, T1s=2 -> one level with level_code=0 (2*2-2-2), suffix_len=0; final suffix_len=1; finish_levels.
- 12 coefficients of value 5, NZQ=12, T1s=0 -> initial suffix_len=1; first level_code=6.
  - After the first level, suffix_len=2 (5>3).
  - 5 > 6 is false, so suffix_len stays 2 for all remaining levels.
- NZQ=0, T1s=0 start -> finish_levels pulse 2 cycles after start; no prefix_start/suffix_start pulses.
- Coefficient -256 as the first level, T1s=3 -> level_code=511, no overflow; suffix_len=0 during coding.
- Assert rst while in PRE_W -> all outputs 0 immediately; a subsequent start_levels runs the full sequence correctly.

Source files
------------

// File: rtl/level_controller.sv
// level_controller
// Level-coding sequencer for a CAVLC 4x4 block. Scans the coefficient BRAM
// in reverse zig-zag order, skips the trailing ones, computes levelCode for
// each remaining non-zero coefficient, tracks suffixLength and drives the
// level_prefix / level_suffix encoders through start/finish handshakes.
//
// Ports
//   clk, rst            clock (rising edge), async active-high reset
//   start_levels        one-cycle start; NZQ (TotalCoeff) and T1s valid with it
//   prefix_finish       prefix encoder done (level)
//   suffix_finish       suffix encoder done (level)
//   mb_bram_data        signed coefficient at mb_bram_address (combinational read)
//   finish_levels       one-cycle completion pulse
//   output_mux          bitstream source select, 0 = prefix, 1 = suffix
//   prefix_start(_out)  prefix encoder compute / shift-out pulses
//   suffix_start(_out)  suffix encoder compute / shift-out pulses
//   mb_bram_en          BRAM read enable, high while scanning
//   mb_bram_address     zig-zag coefficient index
//   suffix_len          current suffixLength (0..6)
//   level_code          levelCode of the current coefficient
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | wait for start_levels
// SCAN      | examine one coefficient per cycle, skip zeros/trailing ones
// CALC      | compute level_code from the latched coefficient
// PRE       | pulse prefix_start
// PRE_W     | wait for prefix_finish
// PRE_OUT   | pulse prefix_start_out, select prefix bits
// PRE_OUT_W | wait for prefix_finish
// SUF       | pulse suffix_start
// SUF_W     | wait for suffix_finish
// SUF_OUT   | pulse suffix_start_out, select suffix bits
// SUF_OUT_W | wait for suffix_finish
// UPDATE    | adapt suffix_len, count the level, continue or finish
// DONE      | raise finish_levels (registered, seen the following cycle)

module level_controller #(
    parameter int DATA_WIDTH  = 9,
    parameter int STATE_WIDTH = 4,
    parameter int NZQ_WIDTH   = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_levels,
    input  logic [NZQ_WIDTH-1:0]         NZQ,
    input  logic [1:0]                   T1s,
    input  logic                         prefix_finish,
    input  logic                         suffix_finish,
    input  logic signed [DATA_WIDTH-1:0] mb_bram_data,
    output logic                         finish_levels,
    output logic                         output_mux,
    output logic                         prefix_start,
    output logic                         prefix_start_out,
    output logic                         suffix_start,
    output logic                         suffix_start_out,
    output logic                         mb_bram_en,
    output logic [3:0]                   mb_bram_address,
    output logic [2:0]                   suffix_len,
    output logic signed [DATA_WIDTH:0]   level_code
);

    localparam int CW = DATA_WIDTH + 2;

    typedef enum logic [STATE_WIDTH-1:0] {
        S_IDLE      = 4'd0,
        S_SCAN      = 4'd1,
        S_CALC      = 4'd2,
        S_PRE       = 4'd3,
        S_PRE_W     = 4'd4,
        S_PRE_OUT   = 4'd5,
        S_PRE_OUT_W = 4'd6,
        S_SUF       = 4'd7,
        S_SUF_W     = 4'd8,
        S_SUF_OUT   = 4'd9,
        S_SUF_OUT_W = 4'd10,
        S_UPDATE    = 4'd11,
        S_DONE      = 4'd12
    } state_t;

    state_t                  state_q, state_d;
    logic [NZQ_WIDTH-1:0]    nzq_q;
    logic [1:0]              t1s_q;
    logic [1:0]              skip_q;
    logic [NZQ_WIDTH-1:0]    enc_q;
    logic [3:0]              addr_q;
    logic signed [DATA_WIDTH-1:0] coeff_q;
    logic signed [DATA_WIDTH:0]   level_code_q;
    logic [2:0]              suffix_len_q;
    logic                    mux_q;
    logic                    finish_q;

    // combinational datapath
    logic                    scan_hit;
    logic                    last_level;
    logic [NZQ_WIDTH-1:0]    enc_inc;
    logic signed [CW-1:0]    c_ext;
    logic signed [CW-1:0]    two_c;
    logic signed [CW-1:0]    lc_full;
    logic signed [CW-1:0]    neg_c;
    logic [DATA_WIDTH:0]     mag;
    logic [DATA_WIDTH:0]     thresh;
    logic [2:0]              sl_bump;
    logic [2:0]              sl_next;

    // A non-zero word is a level only once all trailing ones have been skipped.
    assign scan_hit   = (mb_bram_data != '0) && (skip_q >= t1s_q);
    assign enc_inc    = enc_q + NZQ_WIDTH'(1);
    assign last_level = ((NZQ_WIDTH'(t1s_q) + enc_inc) == nzq_q);

    always_comb begin
        c_ext   = CW'(coeff_q);
        two_c   = c_ext <<< 1;
        neg_c   = -c_ext;
        lc_full = '0;
        if (c_ext > 0) begin
            lc_full = two_c - CW'(2);
        end else begin
            lc_full = -two_c - CW'(1);
        end
        // First coded level after fewer than three trailing ones cannot be +-1.
        if (enc_q == '0 && t1s_q != 2'd3) begin
            lc_full = lc_full - CW'(2);
        end
        mag     = coeff_q[DATA_WIDTH-1] ? neg_c[DATA_WIDTH:0] : c_ext[DATA_WIDTH:0];
        sl_bump = (suffix_len_q == 3'd0) ? 3'd1 : suffix_len_q;
        thresh  = (DATA_WIDTH+1)'(3) << (sl_bump - 3'd1);
        sl_next = sl_bump;
        if (mag > thresh && sl_bump < 3'd6) begin
            sl_next = sl_bump + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_levels) begin
                    state_d = (NZQ == NZQ_WIDTH'(T1s)) ? S_DONE : S_SCAN;
                end
            end
            S_SCAN: begin
                if (scan_hit) begin
                    state_d = S_CALC;
                end else if (addr_q == 4'd0) begin
                    state_d = S_DONE;
                end
            end
            S_CALC:      state_d = S_PRE;
            S_PRE:       state_d = S_PRE_W;
            S_PRE_W:     if (prefix_finish) state_d = S_PRE_OUT;
            S_PRE_OUT:   state_d = S_PRE_OUT_W;
            S_PRE_OUT_W: if (prefix_finish) state_d = S_SUF;
            S_SUF:       state_d = S_SUF_W;
            S_SUF_W:     if (suffix_finish) state_d = S_SUF_OUT;
            S_SUF_OUT:   state_d = S_SUF_OUT_W;
            S_SUF_OUT_W: if (suffix_finish) state_d = S_UPDATE;
            S_UPDATE: begin
                state_d = (last_level || addr_q == 4'd0) ? S_DONE : S_SCAN;
            end
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nzq_q        <= '0;
            t1s_q        <= '0;
            skip_q       <= '0;
            enc_q        <= '0;
            addr_q       <= 4'd15;
            coeff_q      <= '0;
            level_code_q <= '0;
            suffix_len_q <= '0;
            mux_q        <= 1'b0;
            finish_q     <= 1'b0;
        end else begin
            finish_q <= (state_q == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (start_levels) begin
                        nzq_q        <= NZQ;
                        t1s_q        <= T1s;
                        suffix_len_q <= (NZQ > NZQ_WIDTH'(10) && T1s != 2'd3) ? 3'd1 : 3'd0;
                        addr_q       <= 4'd15;
                        skip_q       <= '0;
                        enc_q        <= '0;
                    end
                end
                S_SCAN: begin
                    if (scan_hit) begin
                        coeff_q <= mb_bram_data;
                    end else begin
                        if (mb_bram_data != '0) begin
                            skip_q <= skip_q + 2'd1;
                        end
                        if (addr_q != 4'd0) begin
                            addr_q <= addr_q - 4'd1;
                        end
                    end
                end
                S_CALC:    level_code_q <= lc_full[DATA_WIDTH:0];
                S_PRE_OUT: mux_q <= 1'b0;
                S_SUF_OUT: mux_q <= 1'b1;
                S_UPDATE: begin
                    suffix_len_q <= sl_next;
                    enc_q        <= enc_inc;
                    if (!last_level && addr_q != 4'd0) begin
                        addr_q <= addr_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign finish_levels    = finish_q;
    assign output_mux       = (state_q == S_PRE_OUT) ? 1'b0 :
                              (state_q == S_SUF_OUT) ? 1'b1 : mux_q;
    assign prefix_start     = (state_q == S_PRE);
    assign prefix_start_out = (state_q == S_PRE_OUT);
    assign suffix_start     = (state_q == S_SUF);
    assign suffix_start_out = (state_q == S_SUF_OUT);
    assign mb_bram_en       = (state_q == S_SCAN);
    assign mb_bram_address  = addr_q;
    assign suffix_len       = suffix_len_q;
    assign level_code       = level_code_q;

endmodule

// File: tb/tb_level_controller.sv
// tb_level_controller
// Directed bench for level_controller. Stimulus pushes the expected
// (level_code, suffix_len) of every coded level and the final suffix_len
// into a queue; a monitor pops and compares on each prefix_start and
// finish_levels pulse.

module tb_level_controller;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_levels;
    logic [4:0]        NZQ;
    logic [1:0]        T1s;
    logic              prefix_finish;
    logic              suffix_finish;
    logic signed [8:0] mb_bram_data;
    logic              finish_levels;
    logic              output_mux;
    logic              prefix_start;
    logic              prefix_start_out;
    logic              suffix_start;
    logic              suffix_start_out;
    logic              mb_bram_en;
    logic [3:0]        mb_bram_address;
    logic [2:0]        suffix_len;
    logic signed [9:0] level_code;

    logic signed [8:0] mem [16];

    typedef struct packed {
        logic       is_finish;
        logic [9:0] lc;
        logic [2:0] sl;
    } exp_t;

    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;
    int en_cnt = 0;
    int suf_cnt = 0;

    always #5 clk = ~clk;

    assign mb_bram_data = mem[mb_bram_address];

    level_controller #(.DATA_WIDTH(9), .STATE_WIDTH(4), .NZQ_WIDTH(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_levels     (start_levels),
        .NZQ              (NZQ),
        .T1s              (T1s),
        .prefix_finish    (prefix_finish),
        .suffix_finish    (suffix_finish),
        .mb_bram_data     (mb_bram_data),
        .finish_levels    (finish_levels),
        .output_mux       (output_mux),
        .prefix_start     (prefix_start),
        .prefix_start_out (prefix_start_out),
        .suffix_start     (suffix_start),
        .suffix_start_out (suffix_start_out),
        .mb_bram_en       (mb_bram_en),
        .mb_bram_address  (mb_bram_address),
        .suffix_len       (suffix_len),
        .level_code       (level_code)
    );

    function automatic void check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void push_level(input int lc, input int sl);
        exp_t e;
        e.is_finish = 1'b0;
        e.lc        = 10'(lc);
        e.sl        = 3'(sl);
        exp_q.push_back(e);
    endfunction

    function automatic void push_finish(input int sl);
        exp_t e;
        e.is_finish = 1'b1;
        e.lc        = '0;
        e.sl        = 3'(sl);
        exp_q.push_back(e);
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (mb_bram_en) en_cnt++;
        if (suffix_start) suf_cnt++;
        if (prefix_start_out) check("mux_prefix", int'(output_mux), 0);
        if (suffix_start_out) check("mux_suffix", int'(output_mux), 1);
        if (prefix_start || finish_levels) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                if (prefix_start) begin
                    check("kind_level", int'(e.is_finish), 0);
                    check("level_code", int'(level_code), int'($signed(e.lc)));
                    check("suffix_len_coding", int'(suffix_len), int'(e.sl));
                end else begin
                    check("kind_finish", int'(e.is_finish), 1);
                    check("suffix_len_final", int'(suffix_len), int'(e.sl));
                end
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = '0;
    endtask

    task automatic run_block(input int nzq, input int t1s, input int exp_en,
                             input int exp_lv, input int exp_lat);
        int seen;
        int lat;
        @(negedge clk);
        en_cnt  = 0;
        suf_cnt = 0;
        NZQ = 5'(nzq);
        T1s = 2'(t1s);
        start_levels = 1'b1;
        @(negedge clk);
        start_levels = 1'b0;
        check("finish_not_early", int'(finish_levels), 0);
        seen = 0;
        lat  = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (finish_levels) begin
                seen = 1;
                lat  = i + 2;
                break;
            end
        end
        check("finish_seen", seen, 1);
        if (exp_lat > 0) check("finish_latency", lat, exp_lat);
        check("scan_cycles", en_cnt, exp_en);
        check("suffix_starts", suf_cnt, exp_lv);
        @(negedge clk);
        check("finish_single_pulse", int'(finish_levels), 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        start_levels = 1'b0;
        NZQ = '0;
        T1s = '0;
        prefix_finish = 1'b1;
        suffix_finish = 1'b1;
        clear_mem();
        #23;
        check("reset_outputs", int'({finish_levels, output_mux, prefix_start, prefix_start_out,
                                     suffix_start, suffix_start_out, mb_bram_en, suffix_len,
                                     level_code}), 0);
        check("reset_address", int'(mb_bram_address), 15);
        @(negedge clk);
        rst = 1'b0;

        // trailing ones 1,-1,1 skipped; levels -2 then 3
        clear_mem();
        mem[0] = 9'sd3; mem[1] = -9'sd2; mem[2] = 9'sd1; mem[3] = -9'sd1; mem[4] = 9'sd1;
        push_level(3, 0);
        push_level(4, 1);
        push_finish(1);
        run_block(5, 3, 16, 2, 0);

        // single level after two trailing ones
        clear_mem();
        mem[0] = 9'sd2; mem[1] = 9'sd1; mem[2] = -9'sd1;
        push_level(0, 0);
        push_finish(1);
        run_block(3, 2, 16, 1, 0);

        // twelve 5s, initial suffix_len 1
        clear_mem();
        for (int i = 0; i < 12; i++) mem[i] = 9'sd5;
        push_level(6, 1);
        for (int i = 0; i < 11; i++) push_level(8, 2);
        push_finish(2);
        run_block(12, 0, 16, 12, 0);

        // empty block
        clear_mem();
        push_finish(0);
        run_block(0, 0, 0, 0, 2);

        // most negative coefficient
        clear_mem();
        mem[8] = 9'sd1; mem[7] = -9'sd1; mem[6] = 9'sd1; mem[5] = -9'sd256;
        push_level(511, 0);
        push_finish(2);
        run_block(4, 3, 11, 1, 0);

        // reset while waiting for prefix_finish
        clear_mem();
        mem[0] = 9'sd2; mem[1] = 9'sd1; mem[2] = -9'sd1;
        prefix_finish = 1'b0;
        suffix_finish = 1'b0;
        push_level(0, 0);
        @(negedge clk);
        NZQ = 5'd3;
        T1s = 2'd2;
        start_levels = 1'b1;
        @(negedge clk);
        start_levels = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (prefix_start) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("prefix_start_seen", seen, 1);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_outputs", int'({finish_levels, output_mux, prefix_start, prefix_start_out,
                                     suffix_start, suffix_start_out, mb_bram_en, suffix_len,
                                     level_code}), 0);
        check("abort_address", int'(mb_bram_address), 15);
        repeat (3) @(negedge clk);
        check("abort_no_finish", int'(finish_levels), 0);
        check("abort_queue", exp_q.size(), 0);
        rst = 1'b0;
        prefix_finish = 1'b1;
        suffix_finish = 1'b1;
        push_level(0, 0);
        push_finish(1);
        run_block(3, 2, 16, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
